flag_reader16: RTL and testbench

- Reader side of the 16-bit bitwise-OR flag path. Producers OR event bits into a pending register.
- This block drains the pending register one event at a time. It presents the index of one set bit on a valid/ready interface and clears that bit as it is issued.
- It sits between the 16-bit OR datapath (writer) and the control sequencer (consumer).

---
 rtl/flag_pkg.sv | 10 +
 rtl/flag_reader16_if.sv | 12 +
 rtl/flag_ffs16.sv | 32 +++
 rtl/flag_reader16.sv | 96 +++++++++
 tb/tb_flag_reader16.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/flag_pkg.sv
// Shared constants and types for the 16-bit flag reader path.
package flag_pkg;

    localparam int FLAG_WIDTH = 16;
    localparam int FLAG_IDX_W = 4;

    typedef logic [15:0] flag_vec_t;
    typedef logic [3:0]  flag_idx_t;

endpackage

// File: rtl/flag_reader16_if.sv
// Valid/ready index interface between the flag reader (master) and the sequencer (slave).
interface flag_reader16_if;
    import flag_pkg::*;

    logic      idx_valid;
    logic      idx_ready;
    flag_idx_t idx;

    modport master (output idx_valid, output idx, input idx_ready);
    modport slave  (input idx_valid, input idx, output idx_ready);

endinterface

// File: rtl/flag_ffs16.sv
// Combinational find-first-set over 16 bits, searching upward from start_i with wrap.
module flag_ffs16
    import flag_pkg::*;
(
    input  flag_vec_t vec_i,
    input  flag_idx_t start_i,
    output logic      found_o,
    output flag_idx_t idx_o,
    output flag_vec_t onehot_o
);

    flag_idx_t pos;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        pos      = '0;
        for (int k = 0; k < FLAG_WIDTH; k++) begin
            // 4-bit add wraps naturally past bit 15
            pos = start_i + flag_idx_t'(k);
            if (!found_o && vec_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
        if (found_o) begin
            onehot_o = flag_vec_t'(1) << idx_o;
        end
    end

endmodule

// File: rtl/flag_reader16.sv
// Drains the OR-accumulated pending flag register one index at a time over valid/ready.
// Define FLAG_READER_RR_EN for round-robin selection; default is lowest-index priority.
module flag_reader16
    import flag_pkg::*;
#(
    parameter int WIDTH = FLAG_WIDTH,
    parameter int IDX_W = FLAG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  flag_vec_t         set_vec,
    flag_reader16_if.master   bus,
    output flag_vec_t         pending,
    output logic              dup_seen,
    input  logic              dup_clr
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] issue_mask;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             dup_q, dup_d;

    logic      load;
    logic      issue;
    logic      sel_found;
    flag_idx_t sel_idx;
    flag_vec_t sel_onehot;
    flag_idx_t search_start;

`ifdef FLAG_READER_RR_EN
    flag_idx_t last_q, last_d;

    assign search_start = last_q + 4'd1;
    assign last_d       = issue ? sel_idx : last_q;

    // Reset to the top index so the first search begins at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= flag_idx_t'(WIDTH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign search_start = '0;
`endif

    flag_ffs16 u_ffs (
        .vec_i    (pending_q),
        .start_i  (search_start),
        .found_o  (sel_found),
        .idx_o    (sel_idx),
        .onehot_o (sel_onehot)
    );

    always_comb begin
        load       = !valid_q || bus.idx_ready;
        issue      = load && sel_found;
        issue_mask = issue ? sel_onehot : '0;
        set_mask   = set_en ? set_vec : '0;
        // Set is OR-ed after the clear so a same-cycle re-set keeps the bit pending
        pending_d  = (pending_q & ~issue_mask) | set_mask;
        valid_d    = load ? sel_found : valid_q;
        idx_d      = issue ? sel_idx : idx_q;
        dup_d      = dup_q;
        if (dup_clr) begin
            dup_d = 1'b0;
        end
        if (|(set_mask & pending_q)) begin
            dup_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            dup_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            dup_q     <= dup_d;
        end
    end

    assign bus.idx_valid = valid_q;
    assign bus.idx       = idx_q;
    assign pending       = pending_q;
    assign dup_seen      = dup_q;

endmodule

// File: tb/tb_flag_reader16.sv
// Directed bench for flag_reader16 with a cycle-level reference model and literal pins.
module tb_flag_reader16;
    import flag_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      set_en;
    flag_vec_t set_vec;
    flag_vec_t pending;
    logic      dup_seen;
    logic      dup_clr;
    bit        chk_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    flag_reader16_if bus ();

    flag_reader16 dut (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_vec  (set_vec),
        .bus      (bus),
        .pending  (pending),
        .dup_seen (dup_seen),
        .dup_clr  (dup_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [15:0] m_pend  = '0;
    bit        m_valid = 1'b0;
    int        m_idx   = 0;
    bit        m_dup   = 1'b0;
    int        m_last  = 15;
    int        dut_log[$];

    function automatic int pick(bit [15:0] v, int start);
        for (int k = 0; k < 16; k++) begin
            if (v[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int  sel;
        int  start;
        bit  take;
        bit [15:0] nxt;
        if (bus.idx_valid === 1'b1 && bus.idx_ready === 1'b1 && rst === 1'b0)
            dut_log.push_back(int'(bus.idx));
        if (rst) begin
            m_pend = '0; m_valid = 1'b0; m_idx = 0; m_dup = 1'b0; m_last = 15;
        end else begin
`ifdef FLAG_READER_RR_EN
            start = (m_last + 1) % 16;
`else
            start = 0;
`endif
            take = !m_valid || bus.idx_ready;
            sel  = take ? pick(m_pend, start) : -1;
            if (set_en && ((set_vec & m_pend) != 0)) m_dup = 1'b1;
            else if (dup_clr) m_dup = 1'b0;
            nxt = m_pend;
            if (sel >= 0) nxt[sel] = 1'b0;
            if (set_en) nxt = nxt | set_vec;
            if (take) begin
                if (sel >= 0) begin
                    m_valid = 1'b1; m_idx = sel; m_last = sel;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_pend = nxt;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model idx_valid", 32'(bus.idx_valid), 32'(m_valid));
            cmp("model pending",   32'(pending),       32'(m_pend));
            cmp("model dup_seen",  32'(dup_seen),      32'(m_dup));
            if (m_valid) cmp("model idx", 32'(bus.idx), 32'(m_idx));
        end
    end

    task automatic cyc(input logic r, input logic se, input flag_vec_t sv,
                       input logic rdy, input logic clr);
        rst = r; set_en = se; set_vec = sv; bus.idx_ready = rdy; dup_clr = clr;
        @(negedge clk);
    endtask

    task automatic chk_log(input string name, input int exp[$], input bit exact);
        if (exact) cmp({name, " count"}, 32'(dut_log.size()), 32'(exp.size()));
        else if (dut_log.size() < exp.size())
            cmp({name, " count"}, 32'(dut_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < dut_log.size()) cmp($sformatf("%s[%0d]", name, i), 32'(dut_log[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int exp_q[$];
        rst = 1'b1; set_en = 1'b0; set_vec = '0; dup_clr = 1'b0; bus.idx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // Reset then idle
        repeat (5) cyc(0, 0, 16'h0000, 0, 0);
        cmp("idle valid", 32'(bus.idx_valid), 32'd0);
        cmp("idle pending", 32'(pending), 32'h0000);
        cmp("idle dup", 32'(dup_seen), 32'd0);

        // Burst of four flags drained one per cycle
        dut_log.delete();
        cyc(0, 1, 16'h8421, 1, 0);
        repeat (5) cyc(0, 0, 16'h0000, 1, 0);
        exp_q = '{0, 5, 10, 15};
        chk_log("burst order", exp_q, 1'b1);
        cmp("burst drained valid", 32'(bus.idx_valid), 32'd0);
        cmp("burst drained pending", 32'(pending), 32'h0000);

        // Stall with a new lower set arriving during the stall
        dut_log.delete();
        cyc(0, 1, 16'h0006, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0);
        cmp("stall idx", 32'(bus.idx), 32'd1);
        cyc(0, 0, 16'h0000, 0, 0);
        cyc(0, 1, 16'h0001, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0);
        cmp("stall idx held", 32'(bus.idx), 32'd1);
        cmp("stall valid held", 32'(bus.idx_valid), 32'd1);
        cmp("stall pending", 32'(pending), 32'h0005);
        repeat (4) cyc(0, 0, 16'h0000, 1, 0);
        exp_q = '{1, 0, 2};
        chk_log("stall order", exp_q, 1'b1);

        // Duplicate detection, in-flight re-set, clear priority
        dut_log.delete();
        cyc(0, 1, 16'h0010, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0);
        cyc(0, 1, 16'h0010, 0, 0);
        cmp("inflight reset no dup", 32'(dup_seen), 32'd0);
        cyc(0, 1, 16'h0010, 0, 0);
        cmp("dup set", 32'(dup_seen), 32'd1);
        cyc(0, 0, 16'h0000, 0, 1);
        cmp("dup cleared", 32'(dup_seen), 32'd0);
        cyc(0, 1, 16'h0010, 0, 1);
        cmp("dup beats clear", 32'(dup_seen), 32'd1);
        cyc(0, 0, 16'h0000, 0, 1);
        cyc(0, 1, 16'h0000, 0, 0);
        cmp("empty set no dup", 32'(dup_seen), 32'd0);
        repeat (3) cyc(0, 0, 16'h0000, 1, 0);
        exp_q = '{4, 4};
        chk_log("dup reissue", exp_q, 1'b1);

        // Repeated set of two low bits with ready held high
        dut_log.delete();
        repeat (4) cyc(0, 1, 16'h0003, 1, 0);
        repeat (4) cyc(0, 0, 16'h0000, 1, 0);
`ifdef FLAG_READER_RR_EN
        exp_q = '{0, 1, 0, 1};
`else
        exp_q = '{0, 0, 0, 0};
`endif
        chk_log("repeat order", exp_q, 1'b0);
        cyc(0, 0, 16'h0000, 0, 1);

        // Reset during a stalled handshake
        cyc(0, 1, 16'h0300, 0, 0);
        cyc(0, 0, 16'h0000, 0, 0);
        cmp("pre-reset valid", 32'(bus.idx_valid), 32'd1);
        cmp("pre-reset idx", 32'(bus.idx), 32'd8);
        dut_log.delete();
        cyc(1, 0, 16'h0000, 0, 0);
        cmp("reset valid", 32'(bus.idx_valid), 32'd0);
        cmp("reset pending", 32'(pending), 32'h0000);
        repeat (2) cyc(0, 0, 16'h0000, 1, 0);
        cmp("reset no issue", 32'(dut_log.size()), 32'd0);
        cmp("reset stays idle", 32'(bus.idx_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
